// File: rtl/sha256_digest_tx.sv
`timescale 1ns/1ps
// Captures a SHA-256 digest on the rising edge of the core's ready flag and streams it MSB-first
// over a valid/ready byte handshake. Define DIGEST_TX_HEX_EN to send lowercase ASCII hex instead of raw bytes.
module sha256_digest_tx #(
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] digest_i,
  input  logic                digest_vld_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [6:0]          unit_cnt_o
);

`ifdef DIGEST_TX_HEX_EN
  localparam int UNIT_W = 4;
`else
  localparam int UNIT_W = 8;
`endif
  localparam int         N_UNITS = DIGEST_W / UNIT_W;
  localparam logic [6:0] LAST    = 7'(N_UNITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state_q, state_d;
  logic                vld_q;
  logic                rise;
  logic                accept;
  logic [DIGEST_W-1:0] shreg;
  logic [6:0]          cnt;

  assign rise       = digest_vld_i & ~vld_q;
  assign tx_valid_o = (state_q == SEND);
  assign accept     = tx_valid_o & tx_ready_i;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign unit_cnt_o = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = SEND;
      SEND:    if (accept && cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture only from IDLE so a rise mid-transfer cannot disturb the stream in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      shreg <= '0;
      cnt   <= 7'd0;
    end else begin
      vld_q <= digest_vld_i;
      if (state_q == IDLE && rise) begin
        shreg <= digest_i;
        cnt   <= 7'd0;
      end else if (accept) begin
        shreg <= shreg << UNIT_W;
        cnt   <= cnt + 7'd1;
      end
    end
  end

`ifdef DIGEST_TX_HEX_EN
  logic [3:0] nib;
  logic [7:0] ascii;
  assign nib = shreg[DIGEST_W-1 -: 4];

  always_comb begin
    ascii = 8'h00;
    if (nib < 4'd10) ascii = 8'h30 + {4'h0, nib};
    else             ascii = 8'h57 + {4'h0, nib};
  end

  assign tx_data_o = tx_valid_o ? ascii : 8'h00;
`else
  assign tx_data_o = tx_valid_o ? shreg[DIGEST_W-1 -: 8] : 8'h00;
`endif

endmodule
